refill_beat_router: RTL and testbench

- Reverse-direction companion to the two-input beat arbiter.
- Accepts one merged stream of data beats {id, offset, data} and steers each beat to one of two consumer ports, selected by id.
- Each destination has its own FIFO, so a stalled consumer does not block beats bound for the other port unless the shared input head targets the full FIFO.
- Also tracks beat ordering per destination and flags out-of-sequence offsets.

---
 rtl/refill_beat_router.sv | 121 ++++++++++++
 tb/tb_refill_beat_router.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/refill_beat_router.sv
// Steers a merged stream of refill beats into two per-destination FIFOs selected by id,
// and raises a sticky flag when a destination receives an out-of-sequence beat offset.
module refill_beat_router #(
    parameter int DEPTH    = 2,
    parameter int DATA_W   = 64,
    parameter int OFFSET_W = 3
) (
    input  logic                         clock,
    input  logic                         reset,

    output logic                         io_in_ready,
    input  logic                         io_in_valid,
    input  logic                         io_in_bits_id,
    input  logic [OFFSET_W-1:0]          io_in_bits_offset,
    input  logic [DATA_W-1:0]            io_in_bits_data,

    input  logic                         io_out_0_ready,
    output logic                         io_out_0_valid,
    output logic [OFFSET_W-1:0]          io_out_0_bits_offset,
    output logic [DATA_W-1:0]            io_out_0_bits_data,
    output logic                         io_out_0_bits_last,

    input  logic                         io_out_1_ready,
    output logic                         io_out_1_valid,
    output logic [OFFSET_W-1:0]          io_out_1_bits_offset,
    output logic [DATA_W-1:0]            io_out_1_bits_data,
    output logic                         io_out_1_bits_last,

    output logic [$clog2(DEPTH+1)-1:0]   io_count_0,
    output logic [$clog2(DEPTH+1)-1:0]   io_count_1,
    output logic                         io_order_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [OFFSET_W-1:0] off_mem  [2][DEPTH];
    logic [DATA_W-1:0]   data_mem [2][DEPTH];
    logic [PTR_W-1:0]    wr_ptr   [2];
    logic [PTR_W-1:0]    rd_ptr   [2];
    logic [CNT_W-1:0]    count    [2];
    logic [OFFSET_W-1:0] exp_off  [2];
    logic [1:0]          full;
    logic [1:0]          valid;
    logic [1:0]          enq;
    logic [1:0]          deq;
    logic                accept;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake: a transfer happens on a port exactly in the cycle where valid and ready
    // are both high; ready never looks at valid, and a full FIFO is never ready even while
    // it is being drained in the same cycle.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            full[n]  = (count[n] == CNT_FULL);
            valid[n] = (count[n] != '0);
        end
        io_in_ready = ~full[io_in_bits_id];
        accept      = io_in_valid & io_in_ready;
        enq         = {accept & io_in_bits_id, accept & ~io_in_bits_id};
        deq         = {io_out_1_ready & valid[1], io_out_0_ready & valid[0]};
    end

    // Payload storage carries no reset; only pointers and counts define what is visible.
    always_ff @(posedge clock) begin
        for (int n = 0; n < 2; n++) begin
            if (!reset && enq[n]) begin
                off_mem[n][wr_ptr[n]]  <= io_in_bits_offset;
                data_mem[n][wr_ptr[n]] <= io_in_bits_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                wr_ptr[n]  <= '0;
                rd_ptr[n]  <= '0;
                count[n]   <= '0;
                exp_off[n] <= '0;
            end
            io_order_err <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (enq[n]) begin
                    wr_ptr[n] <= next_ptr(wr_ptr[n]);
                    // Resync on the received offset so one slip is reported once, not forever.
                    if (io_in_bits_offset != exp_off[n])
                        io_order_err <= 1'b1;
                    exp_off[n] <= io_in_bits_offset + OFFSET_W'(1);
                end
                if (deq[n])
                    rd_ptr[n] <= next_ptr(rd_ptr[n]);
                case ({enq[n], deq[n]})
                    2'b10:   count[n] <= count[n] + CNT_W'(1);
                    2'b01:   count[n] <= count[n] - CNT_W'(1);
                    default: count[n] <= count[n];
                endcase
            end
        end
    end

    assign io_out_0_valid       = valid[0];
    assign io_out_0_bits_offset = off_mem[0][rd_ptr[0]];
    assign io_out_0_bits_data   = data_mem[0][rd_ptr[0]];
    assign io_out_0_bits_last   = (off_mem[0][rd_ptr[0]] == '1);

    assign io_out_1_valid       = valid[1];
    assign io_out_1_bits_offset = off_mem[1][rd_ptr[1]];
    assign io_out_1_bits_data   = data_mem[1][rd_ptr[1]];
    assign io_out_1_bits_last   = (off_mem[1][rd_ptr[1]] == '1);

    assign io_count_0 = count[0];
    assign io_count_1 = count[1];

endmodule

// File: tb/tb_refill_beat_router.sv
// Directed bench for refill_beat_router: a queue-based reference model checked on every
// falling edge, plus hand-computed literal expectations along each scenario.
module tb_refill_beat_router;

    localparam int DEPTH    = 2;
    localparam int DATA_W   = 64;
    localparam int OFFSET_W = 3;
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int BW       = OFFSET_W + DATA_W;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                io_in_ready;
    logic                io_in_valid = 1'b0;
    logic                io_in_bits_id = 1'b0;
    logic [OFFSET_W-1:0] io_in_bits_offset = '0;
    logic [DATA_W-1:0]   io_in_bits_data = '0;
    logic                io_out_0_ready = 1'b0;
    logic                io_out_0_valid;
    logic [OFFSET_W-1:0] io_out_0_bits_offset;
    logic [DATA_W-1:0]   io_out_0_bits_data;
    logic                io_out_0_bits_last;
    logic                io_out_1_ready = 1'b0;
    logic                io_out_1_valid;
    logic [OFFSET_W-1:0] io_out_1_bits_offset;
    logic [DATA_W-1:0]   io_out_1_bits_data;
    logic                io_out_1_bits_last;
    logic [CNT_W-1:0]    io_count_0;
    logic [CNT_W-1:0]    io_count_1;
    logic                io_order_err;

    refill_beat_router #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W)) dut (
        .clock(clock), .reset(reset),
        .io_in_ready(io_in_ready), .io_in_valid(io_in_valid),
        .io_in_bits_id(io_in_bits_id), .io_in_bits_offset(io_in_bits_offset),
        .io_in_bits_data(io_in_bits_data),
        .io_out_0_ready(io_out_0_ready), .io_out_0_valid(io_out_0_valid),
        .io_out_0_bits_offset(io_out_0_bits_offset), .io_out_0_bits_data(io_out_0_bits_data),
        .io_out_0_bits_last(io_out_0_bits_last),
        .io_out_1_ready(io_out_1_ready), .io_out_1_valid(io_out_1_valid),
        .io_out_1_bits_offset(io_out_1_bits_offset), .io_out_1_bits_data(io_out_1_bits_data),
        .io_out_1_bits_last(io_out_1_bits_last),
        .io_count_0(io_count_0), .io_count_1(io_count_1),
        .io_order_err(io_order_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [BW-1:0]       exp_q0[$];
    logic [BW-1:0]       exp_q1[$];
    logic [OFFSET_W-1:0] m_exp0 = '0;
    logic [OFFSET_W-1:0] m_exp1 = '0;
    logic                m_err  = 1'b0;
    logic                model_live = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Reference model: one queue per destination, advanced at each rising edge.
    always @(posedge clock) begin
        logic          acc, d0, d1;
        logic [BW-1:0] beat;
        if (reset) begin
            exp_q0.delete();
            exp_q1.delete();
            m_exp0 = '0;
            m_exp1 = '0;
            m_err  = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            acc  = io_in_valid && ((io_in_bits_id ? exp_q1.size() : exp_q0.size()) < DEPTH);
            d0   = io_out_0_ready && (exp_q0.size() > 0);
            d1   = io_out_1_ready && (exp_q1.size() > 0);
            beat = {io_in_bits_offset, io_in_bits_data};
            if (d0) void'(exp_q0.pop_front());
            if (d1) void'(exp_q1.pop_front());
            if (acc && !io_in_bits_id) begin
                if (io_in_bits_offset != m_exp0) m_err = 1'b1;
                m_exp0 = io_in_bits_offset + 1;
                exp_q0.push_back(beat);
            end
            if (acc && io_in_bits_id) begin
                if (io_in_bits_offset != m_exp1) m_err = 1'b1;
                m_exp1 = io_in_bits_offset + 1;
                exp_q1.push_back(beat);
            end
        end
    end

    always @(negedge clock) begin
        if (model_live) begin
            check("in_ready", io_in_ready,
                  ((io_in_bits_id ? exp_q1.size() : exp_q0.size()) < DEPTH));
            check("valid_0", io_out_0_valid, exp_q0.size() > 0);
            check("valid_1", io_out_1_valid, exp_q1.size() > 0);
            check("count_0", io_count_0, exp_q0.size());
            check("count_1", io_count_1, exp_q1.size());
            check("order_err", io_order_err, m_err);
            if (exp_q0.size() > 0) begin
                check("head_0", {io_out_0_bits_offset, io_out_0_bits_data}, exp_q0[0]);
                check("last_0", io_out_0_bits_last, exp_q0[0][BW-1 -: OFFSET_W] == 3'd7);
            end
            if (exp_q1.size() > 0) begin
                check("head_1", {io_out_1_bits_offset, io_out_1_bits_data}, exp_q1[0]);
                check("last_1", io_out_1_bits_last, exp_q1[0][BW-1 -: OFFSET_W] == 3'd7);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic id, input logic [OFFSET_W-1:0] off,
                         input logic [DATA_W-1:0] d);
        io_in_valid       = v;
        io_in_bits_id     = id;
        io_in_bits_offset = off;
        io_in_bits_data   = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        step();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        io_out_0_ready = 1'b1;
        io_out_1_ready = 1'b1;
        do_reset();
        check("rst_valid_0", io_out_0_valid, 1'b0);
        check("rst_valid_1", io_out_1_valid, 1'b0);
        check("rst_in_ready", io_in_ready, 1'b1);
        check("rst_err", io_order_err, 1'b0);

        // Streaming line to out_0: each beat is the head one cycle after its accept.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 3'(i), 64'h100 + 64'(i));
            step();
            check("t1_valid", io_out_0_valid, 1'b1);
            check("t1_data", io_out_0_bits_data, 64'h100 + 64'(i));
            check("t1_last", io_out_0_bits_last, i == 7);
        end
        drive(1'b0, 1'b0, '0, '0);
        step();
        check("t1_drained", io_out_0_valid, 1'b0);
        check("t1_err", io_order_err, 1'b0);

        // Stalled consumer 1 backpressures only id=1 beats.
        io_out_1_ready = 1'b0;
        drive(1'b1, 1'b1, 3'd0, 64'h200);
        step();
        drive(1'b1, 1'b1, 3'd1, 64'h201);
        step();
        check("t2_count_1", io_count_1, 2);
        drive(1'b1, 1'b1, 3'd2, 64'h202);
        #1;
        check("t2_ready_full", io_in_ready, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 64'hAA);
        #1;
        check("t2_ready_other", io_in_ready, 1'b1);
        step();
        check("t2_out0_valid", io_out_0_valid, 1'b1);
        check("t2_out0_data", io_out_0_bits_data, 64'hAA);

        // Full FIFO stays not-ready even while draining in the same cycle.
        drive(1'b1, 1'b1, 3'd2, 64'h202);
        io_out_1_ready = 1'b1;
        #1;
        check("t3_no_passthru", io_in_ready, 1'b0);
        step();
        check("t3_count_after_deq", io_count_1, 1);
        check("t3_head_1", io_out_1_bits_data, 64'h201);
        io_out_1_ready = 1'b0;
        step();
        check("t3_count_back", io_count_1, 2);
        drive(1'b0, 1'b0, '0, '0);
        io_out_1_ready = 1'b1;
        repeat (3) step();
        check("t3_drained", io_count_1, 0);
        check("t3_err", io_order_err, 1'b0);

        // Interleaved destinations, both consumers ready.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 3'(i), 64'h300 + 64'(i));
            step();
            check("t4_count_0", io_count_0, 1);
            drive(1'b1, 1'b1, 3'(i), 64'h400 + 64'(i));
            step();
            check("t4_count_1", io_count_1, 1);
            check("t4_head_1", io_out_1_bits_data, 64'h400 + 64'(i));
        end
        drive(1'b0, 1'b0, '0, '0);
        step();
        check("t4_err", io_order_err, 1'b0);

        // Ordering error: offsets 0,1,3 then a correct 4.
        drive(1'b1, 1'b0, 3'd0, 64'h500);
        step();
        drive(1'b1, 1'b0, 3'd1, 64'h501);
        step();
        check("t5_err_before", io_order_err, 1'b0);
        drive(1'b1, 1'b0, 3'd3, 64'h503);
        step();
        check("t5_err_rise", io_order_err, 1'b1);
        drive(1'b1, 1'b0, 3'd4, 64'h504);
        step();
        check("t5_err_sticky", io_order_err, 1'b1);
        drive(1'b0, 1'b0, '0, '0);
        step();
        do_reset();
        check("t5_err_cleared", io_order_err, 1'b0);

        // Reset discards buffered beats and ignores a beat presented during reset.
        io_out_0_ready = 1'b0;
        io_out_1_ready = 1'b0;
        drive(1'b1, 1'b0, 3'd0, 64'h600); step();
        drive(1'b1, 1'b0, 3'd1, 64'h601); step();
        drive(1'b1, 1'b1, 3'd0, 64'h700); step();
        drive(1'b1, 1'b1, 3'd1, 64'h701); step();
        check("t6_full_0", io_count_0, 2);
        check("t6_full_1", io_count_1, 2);
        reset = 1'b1;
        drive(1'b1, 1'b0, 3'd2, 64'h602);
        io_out_0_ready = 1'b1;
        io_out_1_ready = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        check("t6_valid_0", io_out_0_valid, 1'b0);
        check("t6_valid_1", io_out_1_valid, 1'b0);
        check("t6_count_0", io_count_0, 0);
        check("t6_count_1", io_count_1, 0);
        check("t6_in_ready", io_in_ready, 1'b1);
        repeat (3) begin
            step();
            check("t6_stays_empty", {io_out_1_valid, io_out_0_valid}, 2'b00);
        end

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
